// File: rtl/paddle_ctrl_pkg.sv
// Shared pong definitions: paddle FSM states, delta accumulator sizing and
// the quadrature Gray-code helper used by the encoder decoders.
package paddle_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY1 = 2'd1,
    APPLY2 = 2'd2
  } state_e;

  localparam int DELTA_W   = 4;
  localparam int DELTA_MAX = 7;

  // Position of an {a,b} pair around the quadrature cycle 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    logic [1:0] idx;
    case (ab)
      2'b00:   idx = 2'd0;
      2'b10:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/paddle_ctrl_quad_step.sv
// One encoder channel: 2-flop synchronizer, tick-sampled previous state and
// Gray-code step decode (+1, -1 or 0; illegal double-bit changes give 0).
module quad_step
  import paddle_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_i,
  input  logic              enc_a_i,
  input  logic              enc_b_i,
  output logic signed [1:0] step_o
);

  logic [1:0] sync1_q, sync2_q, prev_q;
  logic [1:0] diff;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      prev_q  <= 2'b00;
    end else begin
      sync1_q <= {enc_a_i, enc_b_i};
      sync2_q <= sync1_q;
      if (tick_i) prev_q <= sync2_q;
    end
  end

  // Modulo-4 distance around the cycle: 1 is forward, 3 is backward, 2 is illegal.
  always_comb begin
    diff   = gray_idx(sync2_q) - gray_idx(prev_q);
    step_o = 2'sb00;
    if (tick_i) begin
      case (diff)
        2'd1:    step_o = 2'sb01;
        2'd3:    step_o = 2'sb11;
        default: step_o = 2'sb00;
      endcase
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller: decimated quadrature decode into saturating
// per-player deltas, committed to the positions once per frame.
module paddle_ctrl
  import paddle_ctrl_pkg::*;
#(
  parameter int POS_W    = 5,
  parameter int POS_MAX  = 24,
  parameter int POS_INIT = 12,
  parameter int DIV_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc1_a,
  input  logic             enc1_b,
  input  logic             enc2_a,
  input  logic             enc2_b,
  input  logic             frame_start,
  output logic [POS_W-1:0] p1_pos,
  output logic [POS_W-1:0] p2_pos,
  output logic             upd
);

  localparam int SUM_W = POS_W + 2;
  localparam logic signed [DELTA_W:0]   DSUM_MAX = (DELTA_W+1)'(DELTA_MAX);
  localparam logic signed [DELTA_W:0]   DSUM_MIN = -DSUM_MAX;
  localparam logic signed [SUM_W-1:0]   PSUM_MAX = SUM_W'(POS_MAX);

  state_e                    state_q, state_d;
  logic [DIV_W-1:0]          div_q;
  logic                      tick;
  logic signed [1:0]         step1, step2;
  logic signed [DELTA_W-1:0] delta1_q, delta1_d, delta2_q, delta2_d;
  logic [POS_W-1:0]          p1_q, p1_d, p2_q, p2_d;
  logic                      upd_q, upd_d;

  function automatic logic signed [DELTA_W-1:0] sat_add(
    input logic signed [DELTA_W-1:0] d,
    input logic signed [1:0]         s
  );
    logic signed [DELTA_W:0] sum;
    sum = $signed({d[DELTA_W-1], d}) + $signed({{(DELTA_W-1){s[1]}}, s});
    if (sum > DSUM_MAX)      sum = DSUM_MAX;
    else if (sum < DSUM_MIN) sum = DSUM_MIN;
    return sum[DELTA_W-1:0];
  endfunction

  function automatic logic [POS_W-1:0] clamp_pos(
    input logic [POS_W-1:0]          pos,
    input logic signed [DELTA_W-1:0] d
  );
    logic signed [SUM_W-1:0] sum;
    logic [POS_W-1:0]        res;
    sum = $signed({2'b00, pos}) + $signed({{(SUM_W-DELTA_W){d[DELTA_W-1]}}, d});
    if (sum < 0)             res = '0;
    else if (sum > PSUM_MAX) res = POS_W'(POS_MAX);
    else                     res = sum[POS_W-1:0];
    return res;
  endfunction

  assign tick = &div_q;

  quad_step u_quad1 (
    .clk     (clk),
    .reset   (reset),
    .tick_i  (tick),
    .enc_a_i (enc1_a),
    .enc_b_i (enc1_b),
    .step_o  (step1)
  );

  quad_step u_quad2 (
    .clk     (clk),
    .reset   (reset),
    .tick_i  (tick),
    .enc_a_i (enc2_a),
    .enc_b_i (enc2_b),
    .step_o  (step2)
  );

  // A step landing on the commit cycle seeds the fresh delta instead of the committed sum.
  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    upd_d    = 1'b0;
    delta1_d = sat_add(delta1_q, step1);
    delta2_d = sat_add(delta2_q, step2);
    case (state_q)
      IDLE: begin
        if (frame_start) state_d = APPLY1;
      end
      APPLY1: begin
        p1_d     = clamp_pos(p1_q, delta1_q);
        delta1_d = {{(DELTA_W-2){step1[1]}}, step1};
        state_d  = APPLY2;
      end
      APPLY2: begin
        p2_d     = clamp_pos(p2_q, delta2_q);
        delta2_d = {{(DELTA_W-2){step2[1]}}, step2};
        upd_d    = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      delta1_q <= '0;
      delta2_q <= '0;
      p1_q     <= POS_W'(POS_INIT);
      p2_q     <= POS_W'(POS_INIT);
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_q + 1'b1;
      delta1_q <= delta1_d;
      delta2_q <= delta2_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      upd_q    <= upd_d;
    end
  end

  assign p1_pos = p1_q;
  assign p2_pos = p2_q;
  assign upd    = upd_q;

endmodule
